// File: rtl/score_keeper.sv
// score_keeper
//   Game-level controller downstream of the collision/scoring stage.
//   Turns the one-cycle start/score/gameEnd pulses into the IDLE/PLAY/OVER
//   game state. Keeps a saturating BCD score and drives active-low
//   7-segment digits. The playing flag gates the bird/pipe logic upstream.
//
//   Optional feature: define HIGH_SCORE_EN to build the best-score register.
//   Without it, best_bcd is tied to zero.
//
//   Parameters
//     DIGITS     number of BCD score digits (1..4)
//
//   Ports
//     clk        in   1          system clock
//     reset      in   1          synchronous, active-high
//     start      in   1          pulse: begin a new game
//     score      in   1          pulse: bird passed a pipe, +1
//     gameEnd    in   1          pulse: collision or bird off-screen
//     playing    out  1          high while in PLAY
//     over       out  1          high while in OVER
//     count_bcd  out  4*DIGITS   current score, digit 0 (LSD) at [3:0]
//     best_bcd   out  4*DIGITS   best score (zero without HIGH_SCORE_EN)
//     hex        out  7*DIGITS   active-low segments {g..a}, digit i at [7i+6:7i]
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset; waits for start, score/gameEnd ignored
//   PLAY  | game running; score pulses count, gameEnd finishes the game
//   OVER  | game finished; score frozen, start begins a new game

module score_keeper #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  score,
    input  logic                  gameEnd,
    output logic                  playing,
    output logic                  over,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [4*DIGITS-1:0]   best_bcd,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_count;
    logic [W-1:0]   w_count_nxt;
    logic [W-1:0]   w_count_inc;
    logic           w_all_nines;
    logic           w_end_game;

    // Ripple-carry BCD increment. At all-nines the count holds instead of
    // wrapping to zero.
    always_comb begin
        logic carry;
        w_count_inc = r_count;
        w_all_nines = 1'b1;
        carry       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_count[4*i +: 4] != 4'd9) begin
                w_all_nines = 1'b0;
            end
            if (carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (w_all_nines) begin
            w_count_inc = r_count;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_end_game  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_PLAY;
                    w_count_nxt = '0;
                end
            end
            S_PLAY: begin
                // gameEnd wins over a coincident score: the point is dropped.
                if (gameEnd) begin
                    w_state_nxt = S_OVER;
                    w_end_game  = 1'b1;
                end else if (score) begin
                    w_count_nxt = w_count_inc;
                end
            end
            S_OVER: begin
                if (start) begin
                    w_state_nxt = S_PLAY;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign playing   = (r_state == S_PLAY);
    assign over      = (r_state == S_OVER);
    assign count_bcd = r_count;

`ifdef HIGH_SCORE_EN
    logic [W-1:0]   r_best;

    // Plain unsigned compare of the packed BCD vectors equals a digit-wise
    // compare from the MSD, since each nibble only holds 0-9.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_best <= '0;
        end else if (w_end_game && (r_count > r_best)) begin
            r_best <= r_count;
        end
    end

    assign best_bcd = r_best;
`else
    assign best_bcd = '0;
`endif

    function automatic logic [6:0] f_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_hex
        assign hex[7*g +: 7] = f_seg(r_count[4*g +: 4]);
    end

endmodule
